tft_rdfuncmod: RTL and testbench
================================

TFT_RDFUNCMOD -- requirements
Module: tft_rdfuncmod

Purpose: 8080-style parallel read engine for the TFT controller bus. It writes a register index, then reads one 16-bit word back. It is the read-direction counterpart of the existing write function module and shares the iCall/oDone handshake.

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- T_WRL, 2, cycles WR_N held low during the index write.
- T_WRH, 2, cycles WR_N held high after the index write, with the index still driven.
- T_RDL, 5, cycles RD_N held low per read strobe; data sampled in the last such cycle.
- T_RDH, 5, cycles RD_N held high after each read strobe.
- DUMMY, 0, 1 means one discarded read strobe precedes the captured read (GRAM reads).
REQ-002 Timing parameters SHALL be legal in the range 1..255; an 8-bit down-counter SHALL time each phase.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be, one per line: name  direction  width  meaning.
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- iCall  in  1  level request; start read.
- oDone  out  1  one-cycle completion pulse.
- iAddr  in  8  register index to read.
- oData  out  16  captured read data.
- TFT_CS_N  out  1  chip select, active low.
- TFT_RS  out  1  1 = data, 0 = command/index.
- TFT_WR_N  out  1  write strobe, active low.
- TFT_RD_N  out  1  read strobe, active low.
- TFT_DB_O  out  16  bus output value.
- TFT_DB_OE  out  1  1 = drive the bus with TFT_DB_O.
- TFT_DB_I  in  16  bus input value.

Function
REQ-005 The FSM SHALL have these states: IDLE, IDX_L, IDX_H, RD_L, RD_H, DONE.
REQ-006 In IDLE, CS_N=1, RS=1, WR_N=1, RD_N=1, OE=0, oDone=0.
REQ-007 In IDLE with iCall=1, the block SHALL latch iAddr, load the counter with T_WRL and enter IDX_L on the next cycle.
REQ-008 In IDX_L, CS_N=0, RS=0, WR_N=0, OE=1, DB_O={8'h00, latched addr}, for exactly T_WRL cycles; the block SHALL then enter IDX_H.
REQ-009 In IDX_H, WR_N=1 while CS_N=0, RS=0, OE=1 and DB_O hold, for exactly T_WRH cycles; the block SHALL then enter RD_L.
REQ-010 In RD_L, CS_N=0, RS=1, RD_N=0, OE=0 from the first RD_L cycle, for exactly T_RDL cycles; the block SHALL then enter RD_H.
REQ-011 TFT_DB_I SHALL be captured into oData at the last RD_L cycle, only on the final strobe; a dummy strobe SHALL NOT update oData.
REQ-012 In RD_H, RD_N=1, CS_N=0, RS=1, OE=0, for exactly T_RDH cycles.
- If a dummy strobe remains, the block SHALL re-enter RD_L.
- Otherwise it SHALL enter DONE.
REQ-013 In DONE, oDone=1 for exactly one cycle, CS_N=1, and all strobes are inactive; the block SHALL return to IDLE next cycle.
REQ-014 Latency SHALL be 1+T_WRL+T_WRH+(1+DUMMY)*(T_RDL+T_RDH) cycles, measured from the IDLE cycle sampling iCall=1 to the oDone cycle; defaults give 15.
REQ-015 iCall SHALL be ignored outside IDLE, and iAddr changes after latching SHALL have no effect.
REQ-016 The caller deasserts iCall in the cycle after oDone; if iCall is still 1 in the following IDLE cycle, a new transaction SHALL start.
REQ-017 oData SHALL hold its value between transactions.
REQ-018 WR_N and RD_N SHALL never be low in the same cycle; OE SHALL be 0 whenever RD_N=0.

Reset
REQ-019 RESET=1 at a clock edge SHALL put the block in IDLE, with outputs at IDLE values, oData=16'h0000 and the counter at 0.
REQ-020 RESET asserted mid-transaction SHALL abort the transaction: CS_N=1 and OE=0 on the next cycle, no oDone pulse, and oData cleared.
REQ-021 RESET SHALL take priority over iCall in the same cycle.

Verification
REQ-022 Defaults, iAddr=8'h22, bus model returns 16'hA5C3 -> WR_N low for 2 cycles with DB_O=16'h0022 and RS=0; RD_N low for 5 cycles with OE=0; oDone exactly 15 cycles after the call; oData=16'hA5C3.
REQ-023 DUMMY=1, bus model returns 16'h1111 on the first strobe and 16'h9325 on the second -> two RD_N pulses; oDone at cycle 25; oData=16'h9325.
REQ-024 iCall held 1 with iAddr changed from 8'h00 to 8'hFF during IDX_H -> DB_O stays 16'h0000; exactly one oDone pulse; a second transaction starts only when iCall is still 1 after DONE.
REQ-025 RESET pulsed during RD_L -> next cycle CS_N=1, RD_N=1, OE=0, oData=0; no oDone pulse; a subsequent call completes normally.
REQ-026 All parameters =1 -> latency 5 cycles; protocol assertions (REQ-018) hold on every cycle across 1000 random back-to-back calls.

Source files
------------

// File: rtl/tft_rdfuncmod.sv
// 8080-style register read engine: writes an 8-bit index, then captures one 16-bit word.
// Shares the iCall/oDone handshake with the write function module.
//   state | meaning
//   IDLE  | bus released, waiting for iCall
//   IDX_L | index driven, WR_N low
//   IDX_H | index still driven, WR_N high
//   RD_L  | bus released by us, RD_N low, sample in last cycle
//   RD_H  | RD_N high recovery; loops back to RD_L for the dummy strobe
//   DONE  | one-cycle completion pulse, CS_N released
module tft_rdfuncmod #(
  parameter int unsigned T_WRL = 2,
  parameter int unsigned T_WRH = 2,
  parameter int unsigned T_RDL = 5,
  parameter int unsigned T_RDH = 5,
  parameter int unsigned DUMMY = 0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        iCall,
  output logic        oDone,
  input  logic [7:0]  iAddr,
  output logic [15:0] oData,
  output logic        TFT_CS_N,
  output logic        TFT_RS,
  output logic        TFT_WR_N,
  output logic        TFT_RD_N,
  output logic [15:0] TFT_DB_O,
  output logic        TFT_DB_OE,
  input  logic [15:0] TFT_DB_I
);

  typedef enum logic [2:0] {IDLE, IDX_L, IDX_H, RD_L, RD_H, DONE} state_t;

  localparam logic [7:0] C_WRL = 8'(T_WRL);
  localparam logic [7:0] C_WRH = 8'(T_WRH);
  localparam logic [7:0] C_RDL = 8'(T_RDL);
  localparam logic [7:0] C_RDH = 8'(T_RDH);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_addr;
  logic        r_dummy, w_dummy_nxt;
  logic        w_last;
  logic        w_capture;

  assign w_last   = (r_cnt == 8'd1);
  assign TFT_DB_O = {8'h00, r_addr};

  // Each phase counter is loaded on entry and the phase ends when it reaches 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dummy_nxt = r_dummy;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (iCall) begin
          w_state_nxt = IDX_L;
          w_cnt_nxt   = C_WRL;
          w_dummy_nxt = (DUMMY != 0);
        end
      end
      IDX_L: begin
        if (w_last) begin
          w_state_nxt = IDX_H;
          w_cnt_nxt   = C_WRH;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      IDX_H: begin
        if (w_last) begin
          w_state_nxt = RD_L;
          w_cnt_nxt   = C_RDL;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      RD_L: begin
        if (w_last) begin
          w_state_nxt = RD_H;
          w_cnt_nxt   = C_RDH;
          w_capture   = !r_dummy;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      RD_H: begin
        if (w_last) begin
          if (r_dummy) begin
            w_state_nxt = RD_L;
            w_cnt_nxt   = C_RDL;
            w_dummy_nxt = 1'b0;
          end else begin
            w_state_nxt = DONE;
            w_cnt_nxt   = 8'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_dummy   <= 1'b0;
      r_addr    <= 8'h00;
      oData     <= 16'h0000;
      oDone     <= 1'b0;
      TFT_CS_N  <= 1'b1;
      TFT_RS    <= 1'b1;
      TFT_WR_N  <= 1'b1;
      TFT_RD_N  <= 1'b1;
      TFT_DB_OE <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dummy <= w_dummy_nxt;
      if (r_state == IDLE && iCall) r_addr <= iAddr;
      if (w_capture) oData <= TFT_DB_I;
      oDone     <= (w_state_nxt == DONE);
      TFT_CS_N  <= (w_state_nxt == IDLE) || (w_state_nxt == DONE);
      TFT_RS    <= !((w_state_nxt == IDX_L) || (w_state_nxt == IDX_H));
      TFT_WR_N  <= (w_state_nxt != IDX_L);
      TFT_RD_N  <= (w_state_nxt != RD_L);
      TFT_DB_OE <= (w_state_nxt == IDX_L) || (w_state_nxt == IDX_H);
    end
  end

endmodule

// File: tb/tb_tft_rdfuncmod.sv
// Bench for tft_rdfuncmod: three instances (defaults, dummy read, all-1 timing) with a
// strobe-accurate bus model and a scoreboard checked on every oDone pulse.
module tb_tft_rdfuncmod;

  typedef struct {
    int          k;
    logic [15:0] data;
    int          cyc;
    logic [15:0] dbo;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst, call;
  logic [2:0][7:0]  addr;
  logic [2:0][15:0] db_i, db_o, odata;
  logic [2:0]       done, cs_n, rs, wr_n, rd_n, oe;
  logic [2:0][15:0] bus_first, bus_second;

  int p_wrl [3] = '{2, 2, 1};
  int p_rdl [3] = '{5, 5, 1};
  int p_dum [3] = '{0, 1, 0};

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  tft_rdfuncmod u0 (
    .CLOCK(clk), .RESET(rst[0]), .iCall(call[0]), .oDone(done[0]), .iAddr(addr[0]),
    .oData(odata[0]), .TFT_CS_N(cs_n[0]), .TFT_RS(rs[0]), .TFT_WR_N(wr_n[0]),
    .TFT_RD_N(rd_n[0]), .TFT_DB_O(db_o[0]), .TFT_DB_OE(oe[0]), .TFT_DB_I(db_i[0]));

  tft_rdfuncmod #(.DUMMY(1)) u1 (
    .CLOCK(clk), .RESET(rst[1]), .iCall(call[1]), .oDone(done[1]), .iAddr(addr[1]),
    .oData(odata[1]), .TFT_CS_N(cs_n[1]), .TFT_RS(rs[1]), .TFT_WR_N(wr_n[1]),
    .TFT_RD_N(rd_n[1]), .TFT_DB_O(db_o[1]), .TFT_DB_OE(oe[1]), .TFT_DB_I(db_i[1]));

  tft_rdfuncmod #(.T_WRL(1), .T_WRH(1), .T_RDL(1), .T_RDH(1), .DUMMY(0)) u2 (
    .CLOCK(clk), .RESET(rst[2]), .iCall(call[2]), .oDone(done[2]), .iAddr(addr[2]),
    .oData(odata[2]), .TFT_CS_N(cs_n[2]), .TFT_RS(rs[2]), .TFT_WR_N(wr_n[2]),
    .TFT_RD_N(rd_n[2]), .TFT_DB_O(db_o[2]), .TFT_DB_OE(oe[2]), .TFT_DB_I(db_i[2]));

  // Bus model: valid data only in the last low cycle of each strobe, garbage otherwise.
  for (genvar g = 0; g < 3; g++) begin : g_bus
    int lowcnt = 0;
    int stb = 0;
    always @(posedge clk) begin
      if (rd_n[g]) lowcnt <= 0;
      else lowcnt <= lowcnt + 1;
      if (cs_n[g]) stb <= 0;
      else if (!rd_n[g] && lowcnt == p_rdl[g] - 1) stb <= stb + 1;
    end
    assign db_i[g] = (!rd_n[g] && lowcnt == p_rdl[g] - 1) ?
                     ((stb == 0) ? bus_first[g] : bus_second[g]) : 16'h0BAD;
  end

  task automatic check(string nm, int k, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=0x%0h exp=0x%0h (t=%0t)", nm, k, got, exp, $time);
    end
  endtask

  int   wr_lo [3];
  int   rd_lo [3];
  int   pls   [3];
  logic [2:0] prev_rd = 3'b111;
  exp_t mon_e;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        wr_lo[k] = 0; rd_lo[k] = 0; pls[k] = 0; prev_rd[k] = 1'b1;
      end else begin
        check("wr_rd_overlap", k, {31'd0, ~wr_n[k] & ~rd_n[k]}, 32'd0);
        check("oe_during_rd", k, {31'd0, ~rd_n[k] & oe[k]}, 32'd0);
        if (!wr_n[k]) begin
          wr_lo[k]++;
          if (sb.size() > 0) begin
            check("idx_dbo", k, {16'd0, db_o[k]}, {16'd0, sb[0].dbo});
            check("idx_rs", k, {31'd0, rs[k]}, 32'd0);
            check("idx_oe", k, {31'd0, oe[k]}, 32'd1);
          end
        end
        if (!rd_n[k]) begin
          rd_lo[k]++;
          if (prev_rd[k]) pls[k]++;
        end
        prev_rd[k] = rd_n[k];
        if (done[k]) begin
          check("done_expected", k, {31'd0, sb.size() > 0}, 32'd1);
          if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("done_dut", k, mon_e.k, k);
            check("odata", k, {16'd0, odata[k]}, {16'd0, mon_e.data});
            check("latency_cycle", k, cyc, mon_e.cyc);
            check("wr_low_cycles", k, wr_lo[k], p_wrl[k]);
            check("rd_low_cycles", k, rd_lo[k], (1 + p_dum[k]) * p_rdl[k]);
            check("rd_pulses", k, pls[k], 1 + p_dum[k]);
            check("done_cs_n", k, {31'd0, cs_n[k]}, 32'd1);
          end
          wr_lo[k] = 0; rd_lo[k] = 0; pls[k] = 0;
        end
      end
    end
  end

  task automatic do_call(int k, logic [7:0] a, logic [15:0] b1, logic [15:0] b2,
                         logic [15:0] exp, int lat);
    exp_t e;
    int n;
    @(negedge clk);
    addr[k] = a; bus_first[k] = b1; bus_second[k] = b2; call[k] = 1'b1;
    e.k = k; e.data = exp; e.cyc = cyc + lat; e.dbo = {8'h00, a};
    sb.push_back(e);
    @(negedge clk);
    call[k] = 1'b0;
    n = 0;
    while (!done[k] && n < lat + 10) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", k, {31'd0, done[k]}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time=%0t limit=2000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    logic [7:0]  ra;
    logic [15:0] rd;
    rst = 3'b111; call = 3'b001; addr = '0; bus_first = '0; bus_second = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_cs_n", k, {31'd0, cs_n[k]}, 32'd1);
      check("rst_rs", k, {31'd0, rs[k]}, 32'd1);
      check("rst_wr_n", k, {31'd0, wr_n[k]}, 32'd1);
      check("rst_rd_n", k, {31'd0, rd_n[k]}, 32'd1);
      check("rst_oe", k, {31'd0, oe[k]}, 32'd0);
      check("rst_done", k, {31'd0, done[k]}, 32'd0);
      check("rst_odata", k, {16'd0, odata[k]}, 32'd0);
    end
    call = 3'b000; rst = 3'b000;
    @(negedge clk);

    do_call(0, 8'h22, 16'hA5C3, 16'h0000, 16'hA5C3, 15);
    repeat (4) @(negedge clk);
    check("odata_hold", 0, {16'd0, odata[0]}, 32'h0000A5C3);
    do_call(0, 8'hB7, 16'h3C69, 16'h0000, 16'h3C69, 15);
    do_call(1, 8'h2E, 16'h1111, 16'h9325, 16'h9325, 25);
    do_call(1, 8'h00, 16'h7E81, 16'h0042, 16'h0042, 25);
    do_call(2, 8'h11, 16'h5AA5, 16'h0000, 16'h5AA5, 5);

    // iCall held through the whole transaction, index changed mid-write
    @(negedge clk);
    c0 = cyc;
    call[0] = 1'b1; addr[0] = 8'h00; bus_first[0] = 16'h4D2B;
    sb.push_back('{0, 16'h4D2B, c0 + 15, 16'h0000});
    sb.push_back('{0, 16'h4D2B, c0 + 31, 16'h00FF});
    repeat (3) @(negedge clk);
    addr[0] = 8'hFF;
    @(negedge clk);
    check("idx_hold_dbo", 0, {16'd0, db_o[0]}, 32'h00000000);
    repeat (13) @(negedge clk);
    call[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("queue_after_hold", 0, sb.size(), 0);

    // reset in the middle of RD_L
    @(negedge clk);
    call[0] = 1'b1; addr[0] = 8'h33; bus_first[0] = 16'hFFFF;
    @(negedge clk);
    call[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("in_rd_l", 0, {31'd0, rd_n[0]}, 32'd0);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_cs_n", 0, {31'd0, cs_n[0]}, 32'd1);
    check("abort_rd_n", 0, {31'd0, rd_n[0]}, 32'd1);
    check("abort_oe", 0, {31'd0, oe[0]}, 32'd0);
    check("abort_odata", 0, {16'd0, odata[0]}, 32'd0);
    check("abort_done", 0, {31'd0, done[0]}, 32'd0);
    rst[0] = 1'b0;
    repeat (20) @(negedge clk);
    do_call(0, 8'h22, 16'hA5C3, 16'h0000, 16'hA5C3, 15);

    // back-to-back random calls at minimum timing
    @(negedge clk);
    call[2] = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rd = 16'($urandom);
      addr[2] = ra; bus_first[2] = rd;
      sb.push_back('{2, rd, cyc + 5, {8'h00, ra}});
      repeat (6) @(negedge clk);
    end
    call[2] = 1'b0;
    repeat (10) @(negedge clk);
    check("queue_empty", 0, sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
